fft64_frame_ctrl: RTL
=====================

# fft64_frame_ctrl

Frame sequencer for the 64-point FFT datapath (the `Stage1_64`…stage chain). Accepts complex samples serially with valid/ready and assembles them into the 64-wide parallel input bus. It holds that bus stable for the datapath's settling latency, captures the parallel result, and streams it out serially. Input and output buffers are separate, so frame N+1 loads while frame N drains.

## Interface
- `WIDTH`, 16, bits per real/imag component (signed)
- `N`, 64, samples per frame (fixed at 64 for this release)
- `DP_LAT`, 1, cycles from `dp_x_*` stable to `dp_y_*` valid; range 0..15
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  input sample accepted when `s_valid && s_ready`
- `s_re`, `s_im`  in  WIDTH each  input sample
- `dp_x_re`, `dp_x_im`  out  WIDTH*N each  frame to datapath; sample k at bits [(k+1)*WIDTH-1 : k*WIDTH]
- `dp_y_re`, `dp_y_im`  in  WIDTH*N each  datapath result, same packing
- `m_valid`  out  1  output sample valid
- `m_ready`  in  1  downstream ready
- `m_re`, `m_im`  out  WIDTH each  output sample
- `m_last`  out  1  high with output sample 63
- `frames_done`  out  16  completed output frames, wraps at 65535→0

## Operation
- Input FSM, states FILL and HOLD; reset state FILL. `s_ready = (state==FILL)`.
- FILL: each handshake writes the sample into slot `wr_idx` of the input buffer and increments `wr_idx` (6-bit). The handshake on slot 63 moves the FSM to HOLD, clears the wait counter, and wraps `wr_idx` to 0.
- HOLD: the input buffer is frozen and `dp_x_*` is stable. The wait counter increments each cycle and saturates at DP_LAT.
- Transfer: occurs on an edge where input is HOLD, wait counter == DP_LAT, and the output buffer is EMPTY, or is DRAIN with the slot-63 handshake on that same edge. On that edge:
  - `dp_y_*` is copied to the output buffer.
  - Input FSM → FILL.
  - Output FSM → DRAIN with `rd_idx` = 0.
- Output FSM, states EMPTY and DRAIN; reset state EMPTY.
  - `m_valid = (state==DRAIN)`.
  - `m_re`/`m_im` = output buffer slot `rd_idx`.
  - `m_last = m_valid && rd_idx==63`.
- DRAIN: each handshake increments `rd_idx`. The slot-63 handshake increments `frames_done` and moves to EMPTY, unless a transfer occurs on the same edge, in which case the FSM stays in DRAIN with `rd_idx` = 0.
- The block performs no arithmetic on samples; it is pure buffering. Counters wrap modulo 64.
- Reset mid-frame discards partial input and output frames. No flush output.

## Timing
- Reset values:
  - `s_ready` = 1
  - `m_valid` = 0, `m_last` = 0
  - `m_re`, `m_im`, `dp_x_*` = 0
  - `frames_done` = 0
- Internal buffers and indices are cleared on reset.
- `dp_x_*` are register outputs and change only on FILL handshakes.
- Latency: the slot-63 input handshake at edge E. With the output buffer EMPTY, the transfer occurs at edge E+1+DP_LAT and `m_valid` rises after it.
- Sustained period with `s_valid` = `m_ready` = 1 throughout: 65+DP_LAT cycles per frame, limited by input.
- `m_ready` low in DRAIN: `m_valid` and data are held and `rd_idx` does not advance. A HOLD frame waits indefinitely, and `s_ready` stays 0.
- `s_valid` low in FILL: nothing is written and `wr_idx` is held.
- Outputs must satisfy AXI-stream rules: once `m_valid` is asserted, data is stable until the handshake.

## Structure
- Package `fft64_pkg`:
  - `FFT_N` = 64
  - `FFT_W` = 16
  - `IDX_W` = 6
  - input state enum {FILL, HOLD}
  - output state enum {EMPTY, DRAIN}
- One sub-module, `fft64_piso`: the N×2×WIDTH output buffer. It provides a parallel load, an indexed read mux, and the `rd_idx` counter with `m_last` generation.
- The input buffer, wait counter and both FSMs live in the top level.

## Test plan
- Reset, then one frame with a passthrough datapath (`dp_y` = `dp_x`), slots 0..31 re=0x0800 im=0, slots 32..63 re=0 im=0x0800 → 64 outputs in order with identical values, `m_last` only on the 64th, `frames_done`=1.
- Same frame with DP_LAT=3 and a bench datapath model that registers `dp_x` for 3 cycles → the first `m_valid` rises exactly 4 cycles after the slot-63 input handshake, and the captured data is correct (no stale data).
- Back-to-back: 4 frames with ramp data (re=k, im=-k), `s_valid` and `m_ready` held high → no lost or duplicated samples, period = 65+DP_LAT cycles, `frames_done`=4.
- Backpressure: `m_ready` low for 200 cycles mid-drain while the next frame loads → `s_ready`=0 after 64 accepts, output data held stable, and both frames delivered intact after release.
- Simultaneous event: the next frame reaches transfer on the same edge as the slot-63 output handshake → `m_valid` stays high with no bubble, and the next output is sample 0 of the new frame.
- Reset asserted after 20 input samples and again during drain → outputs return to their reset values asynchronously, and the following full frame is delivered correctly.

Source files
------------

// File: rtl/fft64_pkg.sv
// Shared constants and FSM state types for the 64-point FFT frame sequencer.
package fft64_pkg;
  localparam int unsigned FFT_N = 64;
  localparam int unsigned FFT_W = 16;
  localparam int unsigned IDX_W = 6;

  typedef enum logic {FILL, HOLD} in_state_t;
  typedef enum logic {EMPTY, DRAIN} out_state_t;
endpackage

// File: rtl/fft64_piso.sv
// Output frame buffer: parallel load of a full result frame, indexed serial readout.
module fft64_piso
  import fft64_pkg::*;
#(
  parameter int unsigned WIDTH = FFT_W,
  parameter int unsigned N     = FFT_N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH*N-1:0] ld_re,
  input  logic [WIDTH*N-1:0] ld_im,
  input  logic               valid,
  input  logic               adv,
  output logic [WIDTH-1:0]   re,
  output logic [WIDTH-1:0]   im,
  output logic               last
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [WIDTH-1:0] mem_re [N];
  logic [WIDTH-1:0] mem_im [N];
  logic [IDX_W-1:0] rd_idx;

  // A load always restarts the readout at slot 0, even mid-handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        mem_re[k] <= '0;
        mem_im[k] <= '0;
      end
      rd_idx <= '0;
    end else if (load) begin
      for (int unsigned k = 0; k < N; k++) begin
        mem_re[k] <= ld_re[k*WIDTH +: WIDTH];
        mem_im[k] <= ld_im[k*WIDTH +: WIDTH];
      end
      rd_idx <= '0;
    end else if (adv) begin
      rd_idx <= rd_idx + 1'b1;
    end
  end

  always_comb begin
    re   = mem_re[rd_idx];
    im   = mem_im[rd_idx];
    last = valid && (rd_idx == LAST_IDX);
  end
endmodule

// File: rtl/fft64_frame_ctrl.sv
// Frame sequencer: serial-in to 64-wide datapath bus, waits DP_LAT, serial-out of results.
module fft64_frame_ctrl
  import fft64_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned N      = 64,
  parameter int unsigned DP_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_re,
  input  logic [WIDTH-1:0]   s_im,
  output logic [WIDTH*N-1:0] dp_x_re,
  output logic [WIDTH*N-1:0] dp_x_im,
  input  logic [WIDTH*N-1:0] dp_y_re,
  input  logic [WIDTH*N-1:0] dp_y_im,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WIDTH-1:0]   m_re,
  output logic [WIDTH-1:0]   m_im,
  output logic               m_last,
  output logic [15:0]        frames_done
);
  localparam logic [3:0]       LAT      = 4'(DP_LAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  in_state_t  in_state,  in_next;
  out_state_t out_state, out_next;

  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wait_cnt;
  logic [WIDTH-1:0] x_re [N];
  logic [WIDTH-1:0] x_im [N];
  logic             s_hs, m_hs, m_end, xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state  <= FILL;
      out_state <= EMPTY;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
    end
  end

  always_comb begin
    s_ready  = (in_state == FILL);
    m_valid  = (out_state == DRAIN);
    s_hs     = s_valid && s_ready;
    m_hs     = m_valid && m_ready;
    m_end    = m_hs && m_last;
    // A draining buffer may be reloaded on the very edge its last sample leaves.
    xfer     = (in_state == HOLD) && (wait_cnt == LAT) &&
               ((out_state == EMPTY) || m_end);
    in_next  = in_state;
    out_next = out_state;
    case (in_state)
      FILL: if (s_hs && (wr_idx == LAST_IDX)) in_next = HOLD;
      HOLD: if (xfer) in_next = FILL;
      default: in_next = FILL;
    endcase
    case (out_state)
      EMPTY: if (xfer) out_next = DRAIN;
      DRAIN: if (m_end && !xfer) out_next = EMPTY;
      default: out_next = EMPTY;
    endcase
  end

  // Wait counter is held at zero throughout FILL, so it starts from 0 on HOLD entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        x_re[k] <= '0;
        x_im[k] <= '0;
      end
      wr_idx      <= '0;
      wait_cnt    <= '0;
      frames_done <= '0;
    end else begin
      if (s_hs) begin
        x_re[wr_idx] <= s_re;
        x_im[wr_idx] <= s_im;
        wr_idx       <= wr_idx + 1'b1;
      end
      if (in_state == FILL) wait_cnt <= '0;
      else if (wait_cnt != LAT) wait_cnt <= wait_cnt + 1'b1;
      if (m_end) frames_done <= frames_done + 1'b1;
    end
  end

  always_comb begin
    dp_x_re = '0;
    dp_x_im = '0;
    for (int unsigned k = 0; k < N; k++) begin
      dp_x_re[k*WIDTH +: WIDTH] = x_re[k];
      dp_x_im[k*WIDTH +: WIDTH] = x_im[k];
    end
  end

  fft64_piso #(.WIDTH(WIDTH), .N(N)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (xfer),
    .ld_re (dp_y_re),
    .ld_im (dp_y_im),
    .valid (m_valid),
    .adv   (m_hs),
    .re    (m_re),
    .im    (m_im),
    .last  (m_last)
  );
endmodule
